wb_pipe_stage: RTL

//   Parametrised pipeline boundary register for MEM->WB and sibling stage boundaries.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/wb_pipe_cell.sv | 36 +++
 rtl/wb_pipe_stage.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: widths and control-field layout shared by the pipeline boundary registers.
package pipe_pkg;

    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 4;
    localparam int WB_CTRL_W  = 2;
    // ALU result + memory read data + destination register index
    localparam int WB_DATA_W  = 2 * WORD_W + REG_ADDR_W;

    // Write-back control bits, MSB first as carried on the ctrl buses.
    typedef struct packed {
        logic wb_en;
        logic mem_r_en;
    } wb_ctrl_t;

endpackage

// File: rtl/wb_pipe_cell.sv
// wb_pipe_cell: one pipeline boundary stage holding valid, control and payload.
// kill beats hold beats shift; a killed or bubble entry always carries zero control.
module wb_pipe_cell #(
    parameter int DATA_W = 68,
    parameter int CTRL_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift,
    input  logic              hold,
    input  logic              kill,
    input  logic              src_valid,
    input  logic [CTRL_W-1:0] src_ctrl,
    input  logic [DATA_W-1:0] src_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // Stage register: kill clears valid/ctrl and leaves data, shift loads the upstream entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (kill) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (shift && !hold) begin
            valid <= src_valid;
            ctrl  <= src_ctrl & {CTRL_W{src_valid}};
            data  <= src_data;
        end
    end

endmodule

// File: rtl/wb_pipe_stage.sv
// wb_pipe_stage: DEPTH chained MEM->WB boundary stages with freeze, flush and occupancy.
// Optional feature: define WB_PIPE_STALL_CNT_EN to add a 16-bit saturating stall_cnt output.
module wb_pipe_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int CTRL_W = WB_CTRL_W,
    parameter int DEPTH  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         freeze,
    input  logic                         flush,
    input  logic                         valid_in,
    input  logic [CTRL_W-1:0]            ctrl_in,
    input  logic [DATA_W-1:0]            data_in,
    output logic                         valid_out,
    output logic [CTRL_W-1:0]            ctrl_out,
    output logic [DATA_W-1:0]            data_out,
`ifdef WB_PIPE_STALL_CNT_EN
    output logic [15:0]                  stall_cnt,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    if (DEPTH < 1 || DEPTH > 8) begin : g_depth_check
        $error("wb_pipe_stage: DEPTH must lie in 1..8");
    end

    logic [DEPTH-1:0]             stg_valid;
    logic [DEPTH-1:0][CTRL_W-1:0] stg_ctrl;
    logic [DEPTH-1:0][DATA_W-1:0] stg_data;
    logic [DEPTH-1:0]             next_valid;

    logic shift;
    logic hold;
    logic kill;

    assign kill  = flush;
    assign hold  = freeze && !flush;
    assign shift = !freeze && !flush;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic              src_valid;
        logic [CTRL_W-1:0] src_ctrl;
        logic [DATA_W-1:0] src_data;

        if (i == 0) begin : g_head
            assign src_valid = valid_in;
            assign src_ctrl  = ctrl_in;
            assign src_data  = data_in;
        end else begin : g_link
            assign src_valid = stg_valid[i-1];
            assign src_ctrl  = stg_ctrl[i-1];
            assign src_data  = stg_data[i-1];
        end

        wb_pipe_cell #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W)
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .shift     (shift),
            .hold      (hold),
            .kill      (kill),
            .src_valid (src_valid),
            .src_ctrl  (src_ctrl),
            .src_data  (src_data),
            .valid     (stg_valid[i]),
            .ctrl      (stg_ctrl[i]),
            .data      (stg_data[i])
        );
    end

    assign valid_out = stg_valid[DEPTH-1];
    assign ctrl_out  = stg_ctrl[DEPTH-1];
    assign data_out  = stg_data[DEPTH-1];

    function automatic logic [OCC_W-1:0] count_ones(input logic [DEPTH-1:0] v);
        logic [OCC_W-1:0] n;
        n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n = n + OCC_W'(v[i]);
        end
        return n;
    endfunction

    // Valid vector the stages will hold after this edge, mirroring the cell priorities.
    always_comb begin
        next_valid = stg_valid;
        if (flush) begin
            next_valid = '0;
        end else if (!freeze) begin
            next_valid[0] = valid_in;
            for (int i = 1; i < DEPTH; i++) begin
                next_valid[i] = stg_valid[i-1];
            end
        end
    end

    // Registered occupancy tracks the popcount of the upcoming valid vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy <= '0;
        end else begin
            occupancy <= count_ones(next_valid);
        end
    end

`ifdef WB_PIPE_STALL_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    // Stall counter: counts frozen edges (a flush edge is not a stall), cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (freeze && !flush) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end
`endif

endmodule
